svm_vector_decoder: RTL and testbench
=====================================

SVM_VECTOR_DECODER -- requirements
Module: svm_vector_decoder

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: system clock; all logic on its rising edge.
REQ-002 The block SHALL have the port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port `synchr_clk`, input, 1 bit: PWM-period marker, synchronous to `clk`; each rising edge starts a new period.
REQ-004 The block SHALL have the port `enable`, input, 1 bit: high = decode and measure; low = idle.
REQ-005 The block SHALL have the ports `K1_A_H`, `K2_A_L`, `K3_B_H`, `K4_B_L`, `K5_C_H`, `K6_C_L`, input, 1 bit each: gate signals (H/L per leg A, B, C).
REQ-006 The block SHALL have the port `vector`, output, 3 bits: decoded switching state {A_H, B_H, C_H}, registered.
REQ-007 The block SHALL have the ports `meas_t0`, `meas_t1`, `meas_t2`, output, 14 bits each: clk counts of zero, single-high and double-high vectors in the last completed period.
REQ-008 The block SHALL have the port `meas_sector`, output, 4 bits: sector 1..6 of the last completed period; 0 = undetermined.
REQ-009 The block SHALL have the port `meas_valid`, output, 1 bit: one-cycle pulse when the `meas_*` outputs update.
REQ-010 The block SHALL have the port `seq_error`, output, 1 bit: the last completed period contained an inconsistent vector set; updated with `meas_valid`.
REQ-011 The block SHALL have the port `shoot_through`, output, 1 bit: sticky fault.

Function
REQ-012 Each cycle, a leg SHALL be "driven" when exactly one of its H/L inputs is 1, "off" when both are 0, and "shorted" when both are 1.
REQ-013 Any shorted leg SHALL set `shoot_through` on the next edge; it SHALL stay set until `rst`.
REQ-014 When all legs are driven, `vector` SHALL equal {K1_A_H, K3_B_H, K5_C_H} one cycle later; otherwise `vector` SHALL hold its value.
REQ-015 Period edge detection SHALL register `synchr_clk` and recognise a rising edge as current=1 and previous=0, giving one cycle of latency.
REQ-016 Classification SHALL apply only when all legs are driven and no leg is shorted:
- 000 or 111 → zero class;
- 100, 010 or 001 → single class;
- 110, 011 or 101 → double class.
Any other cycle SHALL be counted in no class.
REQ-017 Three 14-bit counters SHALL count classified cycles per period; each SHALL saturate at 16383 with no wrap.
REQ-018 The block SHALL record the first single vector and the first double vector seen in the period.
REQ-019 A second, different single vector, or a second, different double vector, in the same period SHALL mark the period inconsistent.
REQ-020 Sector SHALL be decoded from the recorded pair:
- {100,110} → 1; {010,110} → 2; {010,011} → 3;
- {001,011} → 4; {001,101} → 5; {100,101} → 6.
REQ-021 Sector SHALL be 0 if either vector of the pair is missing; this SHALL not be an error.
REQ-022 A non-adjacent pair (e.g. {100,011}) SHALL decode to sector 0 and mark the period inconsistent.
REQ-023 On a detected period edge, the block SHALL, in the same cycle:
- load `meas_t0`, `meas_t1`, `meas_t2`, `meas_sector` and `seq_error` from the finished period;
- pulse `meas_valid` high for one cycle;
- clear the counters, recorded vectors and inconsistency flag.
REQ-024 The sample of the edge cycle SHALL count toward the new period.
REQ-025 The first edge after reset or after `enable` rises SHALL only start a period: no `meas_valid`, outputs unchanged.
REQ-026 When `enable` is low:
- counters and recorded vectors SHALL be held cleared;
- `meas_valid` SHALL stay 0;
- `meas_*` outputs SHALL hold;
- `vector` SHALL be forced to 000;
- `shoot_through` detection SHALL remain active.
REQ-027 If `enable` falls mid-period, that partial period SHALL be discarded with no `meas_valid`.

Reset
REQ-028 When `rst` is high on a clock edge, every output SHALL go to 0:
- `vector` = 000;
- `meas_t0`, `meas_t1`, `meas_t2`, `meas_sector` = 0;
- `meas_valid`, `seq_error`, `shoot_through` = 0.
REQ-029 `rst` SHALL also clear all counters, recorded vectors, the edge-detect register and the first-period flag.
REQ-030 `rst` SHALL take priority over `enable`, `synchr_clk` and the fault inputs.
REQ-031 A reset mid-period SHALL discard that period.

Verification
REQ-032 The bench SHALL cover a normal sector-1 period:
- stimulus: `enable`=1, priming edge, then per period 100 cycles 000, 50 of 100, 30 of 110, 20 of 111, next edge;
- response: `meas_valid` pulse with t0=120, t1=50, t2=30, sector=1, `seq_error`=0.
REQ-033 The bench SHALL cover sector sweep: each of the six legal pairs in turn → `meas_sector` 1..6 respectively.
REQ-034 The bench SHALL cover a non-adjacent pair: 100 then 011 in one period → sector=0, `seq_error`=1.
REQ-035 The bench SHALL cover shoot-through:
- stimulus: K1_A_H=K2_A_L=1 for one cycle;
- response: `shoot_through`=1 on the next edge and held after the inputs recover, until `rst` pulse → 0.
REQ-036 The bench SHALL cover saturation: 20000 cycles of 000 in one period → `meas_t0`=16383.
REQ-037 The bench SHALL cover enable and reset mid-period:
- `enable` dropped mid-period → no `meas_valid`, `vector`=000;
- `rst` mid-period → all outputs 0; the next edge produces no `meas_valid`.

Source files
------------

// File: rtl/svm_vector_decoder_if.sv
// svm_vector_decoder_if: gate inputs, period marker and measurement outputs of the SVM vector decoder
interface svm_vector_decoder_if;
  logic        synchr_clk;
  logic        enable;
  logic        K1_A_H, K2_A_L, K3_B_H, K4_B_L, K5_C_H, K6_C_L;
  logic [2:0]  vector;
  logic [13:0] meas_t0, meas_t1, meas_t2;
  logic [3:0]  meas_sector;
  logic        meas_valid;
  logic        seq_error;
  logic        shoot_through;
  modport master (
    output synchr_clk, enable, K1_A_H, K2_A_L, K3_B_H, K4_B_L, K5_C_H, K6_C_L,
    input  vector, meas_t0, meas_t1, meas_t2, meas_sector, meas_valid, seq_error, shoot_through
  );
  modport slave (
    input  synchr_clk, enable, K1_A_H, K2_A_L, K3_B_H, K4_B_L, K5_C_H, K6_C_L,
    output vector, meas_t0, meas_t1, meas_t2, meas_sector, meas_valid, seq_error, shoot_through
  );
endinterface

// File: rtl/svm_vector_decoder.sv
// svm_vector_decoder: decodes inverter gate patterns into switching vectors and per-PWM-period dwell/sector measurements
module svm_vector_decoder (
  input  logic                 clk,
  input  logic                 rst,
  svm_vector_decoder_if.slave  bus
);
  logic [2:0]  w_v, w_drv;
  logic [1:0]  w_ones;
  logic        w_short, w_all, w_zero, w_single, w_double;
  logic        w_edge, w_cnt, w_start, w_report, w_pair_bad;
  logic [3:0]  w_sector;
  logic        r_sync_prev, r_armed, r_err;
  logic [13:0] r_t0, r_t1, r_t2;
  logic [2:0]  r_sv, r_dv;
  logic [2:0]  r_vector;
  logic [13:0] r_meas_t0, r_meas_t1, r_meas_t2;
  logic [3:0]  r_meas_sector;
  logic        r_meas_valid, r_seq_error, r_shoot;
  assign w_v      = {bus.K1_A_H, bus.K3_B_H, bus.K5_C_H};
  assign w_drv    = {bus.K1_A_H ^ bus.K2_A_L, bus.K3_B_H ^ bus.K4_B_L, bus.K5_C_H ^ bus.K6_C_L};
  assign w_short  = (bus.K1_A_H & bus.K2_A_L) | (bus.K3_B_H & bus.K4_B_L) | (bus.K5_C_H & bus.K6_C_L);
  assign w_all    = &w_drv;
  assign w_ones   = 2'(w_v[0]) + 2'(w_v[1]) + 2'(w_v[2]);
  assign w_zero   = w_all & (w_ones == 2'd0 | w_ones == 2'd3);
  assign w_single = w_all & (w_ones == 2'd1);
  assign w_double = w_all & (w_ones == 2'd2);
  assign w_edge   = bus.synchr_clk & ~r_sync_prev;
  assign w_cnt    = ~rst & bus.enable;
  assign w_start  = ~w_cnt | w_edge;
  assign w_report = w_cnt & w_edge & r_armed;
  // sector from the first single/double pair recorded in the finished period
  always_comb begin
    w_sector = 4'd0;
    case ({r_sv, r_dv})
      6'b100_110: w_sector = 4'd1;
      6'b010_110: w_sector = 4'd2;
      6'b010_011: w_sector = 4'd3;
      6'b001_011: w_sector = 4'd4;
      6'b001_101: w_sector = 4'd5;
      6'b100_101: w_sector = 4'd6;
      default:    w_sector = 4'd0;
    endcase
  end
  assign w_pair_bad = (r_sv != 3'b0) & (r_dv != 3'b0) & (w_sector == 4'd0);
  // period accumulators; a period edge restarts them with the edge-cycle sample, disable/reset holds them clear
  always_ff @(posedge clk) begin
    r_sync_prev <= ~rst & bus.synchr_clk;
    r_armed     <= w_cnt & (r_armed | w_edge);
    r_t0  <= w_start ? 14'(w_cnt & w_zero)   : r_t0 + 14'(w_zero & ~(&r_t0));
    r_t1  <= w_start ? 14'(w_cnt & w_single) : r_t1 + 14'(w_single & ~(&r_t1));
    r_t2  <= w_start ? 14'(w_cnt & w_double) : r_t2 + 14'(w_double & ~(&r_t2));
    r_sv  <= w_start ? (w_cnt & w_single ? w_v : 3'b0) : (w_single & (r_sv == 3'b0) ? w_v : r_sv);
    r_dv  <= w_start ? (w_cnt & w_double ? w_v : 3'b0) : (w_double & (r_dv == 3'b0) ? w_v : r_dv);
    r_err <= w_start ? 1'b0 : r_err | (w_single & (r_sv != 3'b0) & (r_sv != w_v))
                                    | (w_double & (r_dv != 3'b0) & (r_dv != w_v));
  end
  // registered outputs: decoded vector, sticky shoot-through and the per-period measurement snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vector      <= 3'b0;
      r_shoot       <= 1'b0;
      r_meas_valid  <= 1'b0;
      r_meas_t0     <= 14'd0;
      r_meas_t1     <= 14'd0;
      r_meas_t2     <= 14'd0;
      r_meas_sector <= 4'd0;
      r_seq_error   <= 1'b0;
    end else begin
      r_vector     <= ~bus.enable ? 3'b0 : w_all ? w_v : r_vector;
      r_shoot      <= r_shoot | w_short;
      r_meas_valid <= w_report;
      if (w_report) begin
        r_meas_t0     <= r_t0;
        r_meas_t1     <= r_t1;
        r_meas_t2     <= r_t2;
        r_meas_sector <= w_sector;
        r_seq_error   <= r_err | w_pair_bad;
      end
    end
  end
  assign bus.vector        = r_vector;
  assign bus.shoot_through = r_shoot;
  assign bus.meas_valid    = r_meas_valid;
  assign bus.meas_t0       = r_meas_t0;
  assign bus.meas_t1       = r_meas_t1;
  assign bus.meas_t2       = r_meas_t2;
  assign bus.meas_sector   = r_meas_sector;
  assign bus.seq_error     = r_seq_error;
endmodule

// File: tb/tb_svm_vector_decoder.sv
// tb_svm_vector_decoder: directed scenarios for the SVM vector decoder
module tb_svm_vector_decoder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  svm_vector_decoder_if bus();
  svm_vector_decoder dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step_raw(input logic [5:0] k, input logic s);
    {bus.K1_A_H, bus.K2_A_L, bus.K3_B_H, bus.K4_B_L, bus.K5_C_H, bus.K6_C_L} = k;
    bus.synchr_clk = s;
    @(negedge clk);
  endtask
  task automatic step(input logic [2:0] v, input logic s);
    step_raw({v[2], ~v[2], v[1], ~v[1], v[0], ~v[0]}, s);
  endtask
  task automatic run(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) step(v, 1'b0);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.enable = 1'b0;
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    checks++;
    if ({bus.vector, bus.meas_t0, bus.meas_t1, bus.meas_t2, bus.meas_sector, bus.meas_valid, bus.seq_error, bus.shoot_through} !== 54'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {bus.vector, bus.meas_t0, bus.meas_t1, bus.meas_t2, bus.meas_sector, bus.meas_valid, bus.seq_error, bus.shoot_through});
    end
    rst = 1'b0;
  endtask
  task automatic test_sector1;
    bus.enable = 1'b1;
    step(3'b000, 1'b1);
    checks++;
    if (bus.meas_valid !== 1'b0) begin errors++; $display("FAIL prime_no_valid got %b want 0", bus.meas_valid); end
    run(3'b000, 99);
    run(3'b100, 50);
    run(3'b110, 30);
    checks++;
    if (bus.vector !== 3'b110) begin errors++; $display("FAIL vector_110 got %b want 110", bus.vector); end
    run(3'b111, 20);
    step(3'b000, 1'b1);
    checks++;
    if (bus.meas_valid !== 1'b1) begin errors++; $display("FAIL s1_valid got %b want 1", bus.meas_valid); end
    checks++;
    if (bus.meas_t0 !== 14'd120) begin errors++; $display("FAIL s1_t0 got %0d want 120", bus.meas_t0); end
    checks++;
    if (bus.meas_t1 !== 14'd50) begin errors++; $display("FAIL s1_t1 got %0d want 50", bus.meas_t1); end
    checks++;
    if (bus.meas_t2 !== 14'd30) begin errors++; $display("FAIL s1_t2 got %0d want 30", bus.meas_t2); end
    checks++;
    if (bus.meas_sector !== 4'd1) begin errors++; $display("FAIL s1_sector got %0d want 1", bus.meas_sector); end
    checks++;
    if (bus.seq_error !== 1'b0) begin errors++; $display("FAIL s1_seq_error got %b want 0", bus.seq_error); end
    step(3'b000, 1'b0);
    checks++;
    if (bus.meas_valid !== 1'b0) begin errors++; $display("FAIL s1_valid_pulse got %b want 0", bus.meas_valid); end
  endtask
  task automatic test_sector_sweep;
    logic [2:0] sv [6] = '{3'b100, 3'b010, 3'b010, 3'b001, 3'b001, 3'b100};
    logic [2:0] dv [6] = '{3'b110, 3'b110, 3'b011, 3'b011, 3'b101, 3'b101};
    for (int k = 0; k < 6; k++) begin
      run(sv[k], 5);
      run(dv[k], 7);
      step(3'b000, 1'b1);
      checks++;
      if (bus.meas_valid !== 1'b1 || bus.meas_sector !== 4'(k + 1) || bus.seq_error !== 1'b0)
        begin errors++; $display("FAIL sweep_%0d got valid=%b sector=%0d err=%b want 1/%0d/0", k, bus.meas_valid, bus.meas_sector, bus.seq_error, k + 1); end
      checks++;
      if (bus.meas_t1 !== 14'd5 || bus.meas_t2 !== 14'd7)
        begin errors++; $display("FAIL sweep_counts_%0d got t1=%0d t2=%0d want 5/7", k, bus.meas_t1, bus.meas_t2); end
    end
  endtask
  task automatic test_seq_error;
    run(3'b100, 4);
    run(3'b011, 4);
    step(3'b000, 1'b1);
    checks++;
    if (bus.meas_sector !== 4'd0 || bus.seq_error !== 1'b1)
      begin errors++; $display("FAIL nonadjacent got sector=%0d err=%b want 0/1", bus.meas_sector, bus.seq_error); end
    run(3'b100, 3);
    run(3'b010, 3);
    run(3'b110, 3);
    step(3'b000, 1'b1);
    checks++;
    if (bus.meas_sector !== 4'd1 || bus.seq_error !== 1'b1)
      begin errors++; $display("FAIL second_single got sector=%0d err=%b want 1/1", bus.meas_sector, bus.seq_error); end
    run(3'b001, 2);
    run(3'b101, 2);
    step(3'b000, 1'b1);
    checks++;
    if (bus.meas_sector !== 4'd5 || bus.seq_error !== 1'b0)
      begin errors++; $display("FAIL clean_after_error got sector=%0d err=%b want 5/0", bus.meas_sector, bus.seq_error); end
    run(3'b000, 5);
    step(3'b000, 1'b1);
    checks++;
    if (bus.meas_sector !== 4'd0 || bus.seq_error !== 1'b0 || bus.meas_valid !== 1'b1)
      begin errors++; $display("FAIL missing_pair got sector=%0d err=%b valid=%b want 0/0/1", bus.meas_sector, bus.seq_error, bus.meas_valid); end
  endtask
  task automatic test_saturation;
    run(3'b000, 20000);
    step(3'b000, 1'b1);
    checks++;
    if (bus.meas_t0 !== 14'd16383 || bus.meas_t1 !== 14'd0 || bus.meas_t2 !== 14'd0)
      begin errors++; $display("FAIL saturation got t0=%0d t1=%0d t2=%0d want 16383/0/0", bus.meas_t0, bus.meas_t1, bus.meas_t2); end
  endtask
  task automatic test_enable_drop;
    int pulses = 0;
    run(3'b100, 10);
    checks++;
    if (bus.vector !== 3'b100) begin errors++; $display("FAIL en_vector_before got %b want 100", bus.vector); end
    bus.enable = 1'b0;
    step(3'b100, 1'b0);
    checks++;
    if (bus.vector !== 3'b000) begin errors++; $display("FAIL en_vector_forced got %b want 000", bus.vector); end
    step(3'b000, 1'b1);
    pulses += int'(bus.meas_valid);
    for (int i = 0; i < 5; i++) begin step(3'b010, 1'b0); pulses += int'(bus.meas_valid); end
    bus.enable = 1'b1;
    step(3'b000, 1'b1);
    pulses += int'(bus.meas_valid);
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL en_no_valid got %0d pulses want 0", pulses); end
    checks++;
    if (bus.meas_t0 !== 14'd16383) begin errors++; $display("FAIL en_meas_hold got t0=%0d want 16383", bus.meas_t0); end
    run(3'b100, 3);
    step(3'b000, 1'b1);
    checks++;
    if (bus.meas_valid !== 1'b1 || bus.meas_t0 !== 14'd1 || bus.meas_t1 !== 14'd3)
      begin errors++; $display("FAIL en_restart got valid=%b t0=%0d t1=%0d want 1/1/3", bus.meas_valid, bus.meas_t0, bus.meas_t1); end
  endtask
  task automatic test_reset_mid;
    run(3'b110, 10);
    rst = 1'b1;
    step(3'b110, 1'b0);
    checks++;
    if ({bus.vector, bus.meas_t0, bus.meas_t1, bus.meas_t2, bus.meas_sector, bus.meas_valid, bus.seq_error, bus.shoot_through} !== 54'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs got %h want 0", {bus.vector, bus.meas_t0, bus.meas_t1, bus.meas_t2, bus.meas_sector, bus.meas_valid, bus.seq_error, bus.shoot_through});
    end
    rst = 1'b0;
    step(3'b000, 1'b1);
    checks++;
    if (bus.meas_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_first_edge got %b want 0", bus.meas_valid); end
    run(3'b100, 2);
    step(3'b000, 1'b1);
    checks++;
    if (bus.meas_valid !== 1'b1 || bus.meas_t1 !== 14'd2)
      begin errors++; $display("FAIL rst_mid_next_period got valid=%b t1=%0d want 1/2", bus.meas_valid, bus.meas_t1); end
  endtask
  task automatic test_shoot_through;
    step(3'b100, 1'b0);
    checks++;
    if (bus.shoot_through !== 1'b0) begin errors++; $display("FAIL st_clear got %b want 0", bus.shoot_through); end
    step_raw(6'b110101, 1'b0);
    checks++;
    if (bus.shoot_through !== 1'b1 || bus.vector !== 3'b100)
      begin errors++; $display("FAIL st_set got st=%b vec=%b want 1/100", bus.shoot_through, bus.vector); end
    run(3'b010, 3);
    checks++;
    if (bus.shoot_through !== 1'b1 || bus.vector !== 3'b010)
      begin errors++; $display("FAIL st_sticky got st=%b vec=%b want 1/010", bus.shoot_through, bus.vector); end
    rst = 1'b1;
    step(3'b010, 1'b0);
    rst = 1'b0;
    step(3'b010, 1'b0);
    checks++;
    if (bus.shoot_through !== 1'b0) begin errors++; $display("FAIL st_reset got %b want 0", bus.shoot_through); end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.synchr_clk = 1'b0;
    {bus.K1_A_H, bus.K2_A_L, bus.K3_B_H, bus.K4_B_L, bus.K5_C_H, bus.K6_C_L} = 6'b010101;
    test_reset();
    test_sector1();
    test_sector_sweep();
    test_seq_error();
    test_saturation();
    test_enable_drop();
    test_reset_mid();
    test_shoot_through();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
